// File: rtl/memory_arbiter.sv
// Single-port main memory arbiter: the coherence bus's data port has priority over the two icaches,
// with a data-streak counter that bounds instruction starvation and round-robin between the icaches.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic             dwait,
  output logic [31:0]      dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  output logic             mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_D  = 2'd1,
    GNT_I0 = 2'd2,
    GNT_I1 = 2'd3
  } state_e;

  localparam logic [1:0]       RAM_ACCESS = 2'b10;
  localparam logic [1:0]       RAM_ERROR  = 2'b11;
  localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             rr_q, rr_d;

  logic dReq;
  logic iAny;
  logic iIdx;
  logic dAllowed;

  assign dReq     = dREN | dWEN;
  assign iAny     = |iREN;
  assign iIdx     = (state_q == GNT_I1);
  assign dAllowed = (streak_q < LIMIT) || !iAny;

  // Load buses are shared wires; each is only meaningful while its wait is low.
  assign iload = {ramload, ramload};
  assign dload = ramload;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      rr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      rr_q     <= rr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    rr_d     = rr_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 2'b11;
    dwait    = 1'b1;
    mem_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (dReq && dAllowed) begin
          state_d = GNT_D;
        end else if (iAny) begin
          if (iREN == 2'b11) begin
            state_d = rr_q ? GNT_I1 : GNT_I0;
          end else begin
            state_d = iREN[0] ? GNT_I0 : GNT_I1;
          end
        end
      end

      GNT_D: begin
        // A dropped request aborts without touching streak or rr.
        if (!dReq) begin
          state_d = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          mem_err = (ramstate == RAM_ERROR);
          if (ramstate == RAM_ACCESS) begin
            dwait   = 1'b0;
            state_d = IDLE;
            if (iAny) begin
              if (streak_q < LIMIT) begin
                streak_d = streak_q + CNT_W'(1);
              end
            end else begin
              streak_d = '0;
            end
          end
        end
      end

      GNT_I0, GNT_I1: begin
        if (!iREN[iIdx]) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr[iIdx];
          mem_err = (ramstate == RAM_ERROR);
          if (ramstate == RAM_ACCESS) begin
            iwait[iIdx] = 1'b0;
            state_d     = IDLE;
            streak_d    = '0;
            rr_d        = ~rr_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter: inputs change just after the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_memory_arbiter;

  logic             CLK;
  logic             RST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic             dREN;
  logic             dWEN;
  logic [31:0]      daddr;
  logic [31:0]      dstore;
  logic             dwait;
  logic [31:0]      dload;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;
  logic             mem_err;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

  memory_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset();
    RST = 1'b1;
    iREN = 2'b00; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    @(negedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    iREN = 2'b00; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("[TB] FAIL reset_ramREN: got %b expected 0", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL reset_ramWEN: got %b expected 0", ramWEN); end
    checks++; if (ramaddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_ramaddr: got %h expected 0", ramaddr); end
    checks++; if (ramstore !== 32'h0) begin errors++; $display("[TB] FAIL reset_ramstore: got %h expected 0", ramstore); end
    checks++; if (iwait !== 2'b11) begin errors++; $display("[TB] FAIL reset_iwait: got %b expected 11", iwait); end
    checks++; if (dwait !== 1'b1) begin errors++; $display("[TB] FAIL reset_dwait: got %b expected 1", dwait); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_err: got %b expected 0", mem_err); end
    doReset();
  endtask

  task automatic test_single_fetch();
    doReset();
    @(negedge CLK);
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = FREE;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("[TB] FAIL fetch_idle_ramREN: got %b expected 0", ramREN); end
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    checks++; if (ramREN !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ramREN: got %b expected 1", ramREN); end
    checks++; if (ramaddr !== 32'h40) begin errors++; $display("[TB] FAIL fetch_ramaddr: got %h expected 40", ramaddr); end
    checks++; if (iwait !== 2'b10) begin errors++; $display("[TB] FAIL fetch_iwait: got %b expected 10", iwait); end
    checks++; if (iload[0] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL fetch_iload0: got %h expected deadbeef", iload[0]); end
    @(negedge CLK);
    iREN = 2'b00; ramstate = FREE;
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("[TB] FAIL fetch_back_idle: got ramREN=%b iwait=%b expected 0/11", ramREN, iwait); end
  endtask

  task automatic test_data_priority();
    doReset();
    @(negedge CLK);
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'h1234;
    iREN = 2'b11; iaddr[0] = 32'h10; iaddr[1] = 32'h20; ramstate = BUSY;
    @(negedge CLK);
    #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("[TB] FAIL prio_enables: got WEN=%b REN=%b expected 1/0", ramWEN, ramREN); end
    checks++; if (ramstore !== 32'h1234) begin errors++; $display("[TB] FAIL prio_ramstore: got %h expected 1234", ramstore); end
    checks++; if (ramaddr !== 32'h100) begin errors++; $display("[TB] FAIL prio_ramaddr: got %h expected 100", ramaddr); end
    checks++; if (dwait !== 1'b1 || iwait !== 2'b11) begin errors++; $display("[TB] FAIL prio_wait_busy: got dwait=%b iwait=%b expected 1/11", dwait, iwait); end
    @(negedge CLK);
    ramstate = ACCESS;
    #1;
    checks++; if (dwait !== 1'b0 || iwait !== 2'b11) begin errors++; $display("[TB] FAIL prio_complete: got dwait=%b iwait=%b expected 0/11", dwait, iwait); end
    @(negedge CLK);
    dWEN = 1'b0; dREN = 1'b0; iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic test_starvation();
    doReset();
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h200; iREN = 2'b10; iaddr[1] = 32'h80; ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      #1;
      checks++; if (dwait !== 1'b0 || ramaddr !== 32'h200 || iwait !== 2'b11) begin errors++; $display("[TB] FAIL starve_data_%0d: got dwait=%b addr=%h iwait=%b expected 0/200/11", k, dwait, ramaddr, iwait); end
      @(negedge CLK);
      #1;
      checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("[TB] FAIL starve_idle_%0d: got ramREN=%b dwait=%b expected 0/1", k, ramREN, dwait); end
    end
    @(negedge CLK);
    #1;
    checks++; if (iwait !== 2'b01 || ramaddr !== 32'h80 || dwait !== 1'b1) begin errors++; $display("[TB] FAIL starve_icache: got iwait=%b addr=%h dwait=%b expected 01/80/1", iwait, ramaddr, dwait); end
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++; if (dwait !== 1'b0 || iwait !== 2'b11) begin errors++; $display("[TB] FAIL starve_streak_cleared: got dwait=%b iwait=%b expected 0/11", dwait, iwait); end
    @(negedge CLK);
    dREN = 1'b0; iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic test_round_robin();
    doReset();
    @(negedge CLK);
    iREN = 2'b11; iaddr[0] = 32'h10; iaddr[1] = 32'h20; ramstate = ACCESS; ramload = 32'h5A5A0001;
    @(negedge CLK);
    #1;
    checks++; if (iwait !== 2'b10 || ramaddr !== 32'h10) begin errors++; $display("[TB] FAIL rr_first: got iwait=%b addr=%h expected 10/10", iwait, ramaddr); end
    @(negedge CLK);
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("[TB] FAIL rr_idle1: got ramREN=%b iwait=%b expected 0/11", ramREN, iwait); end
    @(negedge CLK);
    #1;
    checks++; if (iwait !== 2'b01 || ramaddr !== 32'h20 || iload[1] !== 32'h5A5A0001) begin errors++; $display("[TB] FAIL rr_second: got iwait=%b addr=%h load=%h expected 01/20/5a5a0001", iwait, ramaddr, iload[1]); end
    @(negedge CLK);
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("[TB] FAIL rr_idle2: got ramREN=%b iwait=%b expected 0/11", ramREN, iwait); end
    @(negedge CLK);
    #1;
    checks++; if (iwait !== 2'b10 || ramaddr !== 32'h10) begin errors++; $display("[TB] FAIL rr_third: got iwait=%b addr=%h expected 10/10", iwait, ramaddr); end
    @(negedge CLK);
    iREN = 2'b01;
    @(negedge CLK);
    #1;
    checks++; if (iwait !== 2'b10) begin errors++; $display("[TB] FAIL rr_single_core0: got iwait=%b expected 10", iwait); end
    @(negedge CLK);
    iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic test_abort();
    doReset();
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h300; iREN = 2'b01; iaddr[0] = 32'h44; ramstate = ACCESS;
    @(negedge CLK);
    #1;
    checks++; if (dwait !== 1'b0) begin errors++; $display("[TB] FAIL abort_setup: got dwait=%b expected 0", dwait); end
    @(negedge CLK);
    ramstate = BUSY;
    @(negedge CLK);
    #1;
    checks++; if (ramREN !== 1'b1 || dwait !== 1'b1 || ramaddr !== 32'h300) begin errors++; $display("[TB] FAIL abort_granted: got REN=%b dwait=%b addr=%h expected 1/1/300", ramREN, dwait, ramaddr); end
    #1 dREN = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL abort_same_cycle: got REN=%b WEN=%b expected 0/0", ramREN, ramWEN); end
    @(negedge CLK);
    #1;
    checks++; if (dut.streak_q !== 3'd1) begin errors++; $display("[TB] FAIL abort_streak: got %0d expected 1", dut.streak_q); end
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h77;
    #1;
    checks++; if (iwait !== 2'b10 || ramaddr !== 32'h44) begin errors++; $display("[TB] FAIL abort_then_ifetch: got iwait=%b addr=%h expected 10/44", iwait, ramaddr); end
    @(negedge CLK);
    iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic test_error();
    doReset();
    @(negedge CLK);
    iREN = 2'b10; iaddr[1] = 32'h60; ramstate = ERROR;
    #1;
    checks++; if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL err_idle: got %b expected 0", mem_err); end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      #1;
      checks++; if (mem_err !== 1'b1 || iwait !== 2'b11 || ramREN !== 1'b1) begin errors++; $display("[TB] FAIL err_pulse_%0d: got err=%b iwait=%b REN=%b expected 1/11/1", k, mem_err, iwait, ramREN); end
    end
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'hCAFE;
    #1;
    checks++; if (mem_err !== 1'b0 || iwait !== 2'b01 || iload[1] !== 32'hCAFE) begin errors++; $display("[TB] FAIL err_complete: got err=%b iwait=%b load=%h expected 0/01/cafe", mem_err, iwait, iload[1]); end
    @(negedge CLK);
    iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic test_async_reset();
    doReset();
    @(negedge CLK);
    iREN = 2'b01; iaddr[0] = 32'h70; ramstate = BUSY;
    @(negedge CLK);
    #1;
    checks++; if (ramREN !== 1'b1) begin errors++; $display("[TB] FAIL arst_granted: got %b expected 1", ramREN); end
    #1 RST = 1'b1;
    #1;
    checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 2'b11 || dwait !== 1'b1 || mem_err !== 1'b0) begin errors++; $display("[TB] FAIL arst_immediate: got REN=%b addr=%h iwait=%b dwait=%b err=%b expected 0/0/11/1/0", ramREN, ramaddr, iwait, dwait, mem_err); end
    #1 RST = 1'b0;
    @(negedge CLK);
    ramstate = ACCESS; ramload = 32'h99;
    #1;
    checks++; if (iwait !== 2'b10 || ramaddr !== 32'h70 || ramREN !== 1'b1) begin errors++; $display("[TB] FAIL arst_rearb: got iwait=%b addr=%h REN=%b expected 10/70/1", iwait, ramaddr, ramREN); end
    @(negedge CLK);
    iREN = 2'b00; ramstate = FREE;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_priority();
    test_starvation();
    test_round_robin();
    test_abort();
    test_error();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
